// File: rtl/prio_mixer_if.sv
// Pixel request, priority PROM and pixel output bundle for prio_mixer.
// The master side is the pixel source plus PROM; the slave side is the mixer.
interface prio_mixer_if #(
   parameter int COLW = 8
);
   logic            IN_VALID;
   logic            IN_READY;
   logic [2:0]      OBP;
   logic            NFIX;
   logic            NOBJ;
   logic            NVB;
   logic            NVA;
   logic [COLW-1:0] COL_FIX;
   logic [COLW-1:0] COL_OBJ;
   logic [COLW-1:0] COL_VB;
   logic [COLW-1:0] COL_VA;
   logic [COLW-1:0] BGCOL;
   logic [7:0]      PADDR;
   logic            EN1n;
   logic            EN2n;
   logic [3:0]      PQ;
   logic            OUT_VALID;
   logic            OUT_READY;
   logic [COLW-1:0] PIX;
   logic            SHADOW;

   modport master (
      output IN_VALID, OBP, NFIX, NOBJ, NVB, NVA,
             COL_FIX, COL_OBJ, COL_VB, COL_VA, BGCOL, PQ, OUT_READY,
      input  IN_READY, PADDR, EN1n, EN2n, OUT_VALID, PIX, SHADOW
   );

   modport slave (
      input  IN_VALID, OBP, NFIX, NOBJ, NVB, NVA,
             COL_FIX, COL_OBJ, COL_VB, COL_VA, BGCOL, PQ, OUT_READY,
      output IN_READY, PADDR, EN1n, EN2n, OUT_VALID, PIX, SHADOW
   );
endinterface

// File: rtl/prio_mixer.sv
// Layer priority mixer: looks up a priority PROM per pixel and selects one of four layer colours.
// Optional macro PRIO_SHADOW_EN routes PROM bit Q2 to SHADOW; otherwise SHADOW is tied low.
module prio_mixer #(
   parameter int PROM_WAIT = 3,
   parameter int COLW      = 8
) (
   input logic        CLK,
   input logic        RESn,
   prio_mixer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      HOLD
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [2:0]      obp_q;
   logic [3:0]      nFlags_q;
   logic [COLW-1:0] colFix_q, colObj_q, colVb_q, colVa_q, bgCol_q;
   logic [COLW-1:0] pix_q, pix_d;
   logic            shadow_q, shadow_d;
   logic            accept;
   logic            sample;
   logic            allTransparent;
   logic            unusedPq;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      sample  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.IN_VALID) begin
               accept  = 1'b1;
               cnt_d   = 4'(PROM_WAIT - 1);
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               sample  = 1'b1;
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         HOLD: begin
            if (bus.OUT_READY) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Backdrop wins whenever every layer is transparent, whatever the PROM says.
   assign allTransparent = (nFlags_q == 4'hF);

   always_comb begin
      pix_d = colFix_q;
      unique case (bus.PQ[1:0])
         2'd0: pix_d = colFix_q;
         2'd1: pix_d = colObj_q;
         2'd2: pix_d = colVb_q;
         2'd3: pix_d = colVa_q;
         default: pix_d = colFix_q;
      endcase
      if (allTransparent) begin
         pix_d = bgCol_q;
      end
   end

`ifdef PRIO_SHADOW_EN
   assign shadow_d = bus.PQ[2] & ~allTransparent;
   assign unusedPq = bus.PQ[3];
`else
   assign shadow_d = 1'b0;
   assign unusedPq = ^bus.PQ[3:2];
`endif

   always_ff @(posedge CLK) begin
      if (!RESn) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         obp_q    <= 3'd0;
         nFlags_q <= 4'd0;
         colFix_q <= '0;
         colObj_q <= '0;
         colVb_q  <= '0;
         colVa_q  <= '0;
         bgCol_q  <= '0;
         pix_q    <= '0;
         shadow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            obp_q    <= bus.OBP;
            nFlags_q <= {bus.NFIX, bus.NOBJ, bus.NVB, bus.NVA};
            colFix_q <= bus.COL_FIX;
            colObj_q <= bus.COL_OBJ;
            colVb_q  <= bus.COL_VB;
            colVa_q  <= bus.COL_VA;
            bgCol_q  <= bus.BGCOL;
         end
         if (sample) begin
            pix_q    <= pix_d;
            shadow_q <= shadow_d;
         end
      end
   end

   // OBP bits are wired to the PROM address in reversed order.
   assign bus.PADDR     = {1'b0, obp_q[0], obp_q[1], obp_q[2], nFlags_q};
   assign bus.IN_READY  = (state_q == IDLE);
   assign bus.EN1n      = (state_q != ACCESS);
   assign bus.EN2n      = (state_q != ACCESS);
   assign bus.OUT_VALID = (state_q == HOLD);
   assign bus.PIX       = pix_q;
   assign bus.SHADOW    = shadow_q;

endmodule

// File: tb/tb_prio_mixer.sv
// Scoreboard bench for prio_mixer: a PROM table model answers lookups, expected pixels are
// queued at each accepted request and compared by a negedge monitor when the mixer presents them.
module tb_prio_mixer;

   localparam int PROM_WAIT = 3;
   localparam int COLW      = 8;

   logic CLK  = 1'b0;
   logic RESn = 1'b0;

   always #5 CLK = ~CLK;

   prio_mixer_if #(.COLW(COLW)) bus ();

   prio_mixer #(
      .PROM_WAIT(PROM_WAIT),
      .COLW     (COLW)
   ) dut (
      .CLK (CLK),
      .RESn(RESn),
      .bus (bus)
   );

   // PROM contents; outside an access the data lines show garbage so mistimed sampling shows up.
   logic [3:0] promMem [256];
   assign bus.PQ = bus.EN1n ? ~promMem[bus.PADDR] : promMem[bus.PADDR];

   typedef struct {
      logic [7:0]      addr;
      logic [COLW-1:0] pix;
      logic            shadow;
      int              cyc;
   } exp_t;

   exp_t sb[$];
   int   checks    = 0;
   int   errors    = 0;
   int   cyc       = 0;
   int   lastXfer  = -1;
   int   xferCount = 0;
   bit   b2b       = 1'b0;
   bit   randReady = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: what the pixel should be, from the request fields and the PROM table.
   function automatic exp_t model(input logic [2:0] obp, input logic [3:0] n,
                                  input logic [COLW-1:0] cf, input logic [COLW-1:0] co,
                                  input logic [COLW-1:0] cvb, input logic [COLW-1:0] cva,
                                  input logic [COLW-1:0] bg);
      exp_t            e;
      logic [COLW-1:0] layers [4];
      logic [3:0]      q;
      e.addr = {1'b0, obp[0], obp[1], obp[2], n};
      q      = promMem[e.addr];
      layers = '{cf, co, cvb, cva};
      e.cyc  = 0;
      if (n == 4'hF) begin
         e.pix    = bg;
         e.shadow = 1'b0;
      end else begin
         e.pix = layers[q[1:0]];
`ifdef PRIO_SHADOW_EN
         e.shadow = q[2];
`else
         e.shadow = 1'b0;
`endif
      end
      return e;
   endfunction

   // Request-side observer: queue an expectation on every accepted pixel.
   always @(posedge CLK) begin
      exp_t e;
      if (!RESn) begin
         sb.delete();
         lastXfer = -1;
      end else if (bus.IN_VALID && bus.IN_READY) begin
         e = model(bus.OBP, {bus.NFIX, bus.NOBJ, bus.NVB, bus.NVA},
                   bus.COL_FIX, bus.COL_OBJ, bus.COL_VB, bus.COL_VA, bus.BGCOL);
         e.cyc = cyc;
         sb.push_back(e);
         xferCount++;
         if (b2b && lastXfer >= 0) begin
            checkOutput("issue_interval", 32'(cyc - lastXfer), 32'(PROM_WAIT + 2));
         end
         lastXfer = b2b ? cyc : -1;
      end
      cyc++;
   end

   // Output monitor: timing of the enables and valid follows from the oldest outstanding request.
   always @(negedge CLK) begin
      bit expAccess;
      int d;
      expAccess = 1'b0;
      if (RESn) begin
         if (sb.size() > 0) begin
            d         = cyc - sb[0].cyc - 1;
            expAccess = (d < PROM_WAIT);
         end
         checkOutput("in_ready", bus.IN_READY, sb.size() == 0);
         checkOutput("en1n", bus.EN1n, !expAccess);
         checkOutput("en2n", bus.EN2n, !expAccess);
         checkOutput("out_valid", bus.OUT_VALID, sb.size() > 0 && !expAccess);
         if (sb.size() > 0) begin
            checkOutput("paddr", bus.PADDR, sb[0].addr);
         end
         if (bus.OUT_VALID && sb.size() > 0) begin
            checkOutput("pix", bus.PIX, sb[0].pix);
            checkOutput("shadow", bus.SHADOW, sb[0].shadow);
            if (bus.OUT_READY) begin
               void'(sb.pop_front());
            end
         end
      end
   end

   always @(posedge CLK) begin
      if (randReady) begin
         #1 bus.OUT_READY = 1'($urandom_range(0, 1));
      end
   end

   task automatic applyStimulus(input logic [2:0] obp, input logic [3:0] n,
                                input logic [COLW-1:0] cf, input logic [COLW-1:0] co,
                                input logic [COLW-1:0] cvb, input logic [COLW-1:0] cva,
                                input logic [COLW-1:0] bg);
      bit done;
      done = 1'b0;
      bus.OBP      = obp;
      {bus.NFIX, bus.NOBJ, bus.NVB, bus.NVA} = n;
      bus.COL_FIX  = cf;
      bus.COL_OBJ  = co;
      bus.COL_VB   = cvb;
      bus.COL_VA   = cva;
      bus.BGCOL    = bg;
      bus.IN_VALID = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(posedge CLK);
         if (bus.IN_READY) done = 1'b1;
      end
      #1 bus.IN_VALID = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: actual=no_accept required=accept");
      end
   endtask

   task automatic randomPixel();
      logic [3:0] n;
      n = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      applyStimulus(3'($urandom), n, 8'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), 8'($urandom));
   endtask

   task automatic waitDrain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge CLK);
         if (sb.size() == 0) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: actual=%0d pending required=0", sb.size());
      end
   endtask

   // Fixed vector: three enabled cycles, then the pixel appears with the given constants.
   task automatic directedCheck(input string tag, input logic [2:0] obp, input logic [3:0] n,
                                input logic [3:0] pq, input logic [7:0] expAddr,
                                input logic [COLW-1:0] cva, input logic [COLW-1:0] bg,
                                input logic [COLW-1:0] expPix, input logic expShadow);
      promMem[expAddr] = pq;
      bus.OUT_READY    = 1'b1;
      applyStimulus(obp, n, 8'h11, 8'h22, 8'h33, cva, bg);
      for (int i = 0; i < PROM_WAIT; i++) begin
         @(negedge CLK);
         checkOutput({tag, "_en_low"}, {bus.EN1n, bus.EN2n}, 2'b00);
         checkOutput({tag, "_not_valid"}, bus.OUT_VALID, 1'b0);
      end
      checkOutput({tag, "_paddr"}, bus.PADDR, expAddr);
      @(negedge CLK);
      checkOutput({tag, "_valid"}, bus.OUT_VALID, 1'b1);
      checkOutput({tag, "_pix"}, bus.PIX, expPix);
      checkOutput({tag, "_shadow"}, bus.SHADOW, expShadow);
      waitDrain();
   endtask

   initial begin
      logic [COLW-1:0] heldPix;
      bit              seen;
      int              startCount;
      bus.IN_VALID  = 1'b0;
      bus.OUT_READY = 1'b0;
      bus.OBP       = '0;
      {bus.NFIX, bus.NOBJ, bus.NVB, bus.NVA} = '0;
      bus.COL_FIX   = '0;
      bus.COL_OBJ   = '0;
      bus.COL_VB    = '0;
      bus.COL_VA    = '0;
      bus.BGCOL     = '0;
      for (int i = 0; i < 256; i++) promMem[i] = 4'($urandom_range(0, 15));

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      checkOutput("rst_en", {bus.EN1n, bus.EN2n}, 2'b11);
      checkOutput("rst_valid", bus.OUT_VALID, 1'b0);
      checkOutput("rst_paddr", bus.PADDR, 8'h00);
      checkOutput("rst_pix", bus.PIX, 8'h00);
      checkOutput("rst_shadow", bus.SHADOW, 1'b0);
      @(posedge CLK);
      #1 RESn = 1'b1;
      @(negedge CLK);
      checkOutput("rst_in_ready", bus.IN_READY, 1'b1);

      directedCheck("obp101", 3'b101, 4'b0000, 4'h1, 8'h50, 8'h44, 8'h55, 8'h22, 1'b0);
      directedCheck("backdrop", 3'b000, 4'b1111, 4'h2, 8'h0F, 8'h44, 8'hA5, 8'hA5, 1'b0);
`ifdef PRIO_SHADOW_EN
      directedCheck("va_shadow", 3'b000, 4'b0000, 4'h7, 8'h00, 8'h3C, 8'h55, 8'h3C, 1'b1);
`else
      directedCheck("va_shadow", 3'b000, 4'b0000, 4'h7, 8'h00, 8'h3C, 8'h55, 8'h3C, 1'b0);
`endif

      // Output stall: new requests must be refused while the pixel is held.
      @(posedge CLK);
      #1 bus.OUT_READY = 1'b0;
      randomPixel();
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge CLK);
         if (bus.OUT_VALID) seen = 1'b1;
      end
      checkOutput("stall_reach_hold", seen, 1'b1);
      heldPix = bus.PIX;
      @(posedge CLK);
      #1 bus.IN_VALID = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         checkOutput("stall_valid", bus.OUT_VALID, 1'b1);
         checkOutput("stall_pix", bus.PIX, heldPix);
         checkOutput("stall_in_ready", bus.IN_READY, 1'b0);
      end
      @(posedge CLK);
      #1;
      bus.IN_VALID  = 1'b0;
      bus.OUT_READY = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      checkOutput("release_in_ready", bus.IN_READY, 1'b1);
      checkOutput("release_valid", bus.OUT_VALID, 1'b0);

      // Reset in the middle of a PROM access.
      @(posedge CLK);
      #1;
      randomPixel();
      @(posedge CLK);
      #1 RESn = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      checkOutput("abort_en", {bus.EN1n, bus.EN2n}, 2'b11);
      checkOutput("abort_valid", bus.OUT_VALID, 1'b0);
      @(posedge CLK);
      #1 RESn = 1'b1;
      @(negedge CLK);
      checkOutput("abort_in_ready", bus.IN_READY, 1'b1);

      // Back-to-back requests with the output always ready.
      @(posedge CLK);
      #1;
      b2b        = 1'b1;
      startCount = xferCount;
      bus.IN_VALID = 1'b1;
      for (int i = 0; i < 40 && (xferCount - startCount) < 6; i++) begin
         @(posedge CLK);
         #1;
         bus.OBP     = 3'($urandom);
         {bus.NFIX, bus.NOBJ, bus.NVB, bus.NVA} = 4'($urandom);
         bus.COL_FIX = 8'($urandom);
         bus.COL_OBJ = 8'($urandom);
         bus.COL_VB  = 8'($urandom);
         bus.COL_VA  = 8'($urandom);
         bus.BGCOL   = 8'($urandom);
      end
      bus.IN_VALID = 1'b0;
      b2b          = 1'b0;
      checkOutput("b2b_count", 32'(xferCount - startCount), 32'd6);
      waitDrain();

      // Random traffic with random output back-pressure.
      randReady = 1'b1;
      for (int i = 0; i < 30; i++) begin
         randomPixel();
         repeat ($urandom_range(0, 3)) @(posedge CLK);
         #1;
      end
      randReady = 1'b0;
      @(posedge CLK);
      #2 bus.OUT_READY = 1'b1;
      waitDrain();
      repeat (3) @(posedge CLK);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
